// File: rtl/dram_arb_pkg.sv
// ----------------------------------------------------------------------------
// dram_arb_pkg
// Shared definitions for the data RAM arbiter: the sequencer state encoding,
// the requester port indices and the Enable/Disable constants used across
// the codebase.
// Ports: none (package).
// ----------------------------------------------------------------------------
package dram_arb_pkg;

    // Sequencer states: one request is latched in IDLE, driven onto the RAM
    // in ACCESS and acknowledged in RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester indices: port 0 is the CPU memory stage, port 1 the
    // DMA/debug loader.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// data_ram_arbiter_if
// One requester port of the data RAM arbiter (request/command bundle plus the
// acknowledge and registered read data that come back).
// Signals:
//   req    request, held high by the master until ack
//   we     write (1) / read (0)
//   addr   byte address (AW bits)
//   sel    byte lanes (DW/8 bits)
//   wdata  write data (DW bits)
//   ack    single-cycle completion pulse
//   rdata  registered read data (DW bits)
// Modports: master (requester side), slave (arbiter side).
// ----------------------------------------------------------------------------
interface data_ram_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW/8-1:0] sel;
    logic [DW-1:0]   wdata;
    logic            ack;
    logic [DW-1:0]   rdata;

    modport master (
        output req, we, addr, sel, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/dram_arb_pick.sv
// ----------------------------------------------------------------------------
// dram_arb_pick
// Combinational winner selection between the two requesters.
// Ports:
//   req0, req1   request bits of port 0 / port 1
//   last_winner  index of the port that won the previous grant
//   winner       index of the port granted now
//   valid        at least one request is present
// A single request always wins. On a simultaneous request the port that did
// not win last is chosen; tying last_winner to PORT_DMA turns this into fixed
// priority for port 0.
// ----------------------------------------------------------------------------
module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = ~last_winner;
        end else if (req1) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// ----------------------------------------------------------------------------
// data_ram_arbiter
// Two-port arbiter and sequencer in front of the byte-lane data RAM
// (synchronous write, combinational read). One request is latched at a time,
// driven onto the RAM for exactly one cycle, and acknowledged one cycle later.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   m0         port 0 (CPU memory stage), slave side of data_ram_arbiter_if
//   m1         port 1 (DMA/debug loader), slave side of data_ram_arbiter_if
//   ram_ce     RAM enable, high only in ACCESS
//   ram_we     RAM write enable
//   ram_addr   RAM address (AW bits)
//   ram_sel    RAM byte lanes (DW/8 bits)
//   ram_wdata  RAM write data (DW bits)
//   ram_rdata  RAM combinational read data (DW bits)
//   busy       high whenever the state is not IDLE
// Configuration macro: DRAM_ARB_RR_EN selects round-robin arbitration;
// without it port 0 has fixed priority and no pointer register exists.
// ----------------------------------------------------------------------------
module data_ram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    data_ram_arbiter_if.slave m0,
    data_ram_arbiter_if.slave m1,
    output logic            ram_ce,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW/8-1:0] ram_sel,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata,
    output logic            busy
);

    state_t          state;
    state_t          state_next;

    logic            cmd_we;
    logic            cmd_port;
    logic [AW-1:0]   cmd_addr;
    logic [DW/8-1:0] cmd_sel;
    logic [DW-1:0]   cmd_wdata;

    logic [DW-1:0]   rdata0;
    logic [DW-1:0]   rdata1;
    logic            ack0;
    logic            ack1;

    logic            grant_valid;
    logic            grant_port;
    logic            last_winner;
    logic            grant_take;

    // A grant is taken only when a request is sampled in IDLE.
    assign grant_take = (state == IDLE) && grant_valid;

`ifdef DRAM_ARB_RR_EN
    // Last-winner pointer; starts as "port 1 last" so port 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_winner <= PORT_DMA;
        end else if (grant_take) begin
            last_winner <= grant_port;
        end
    end
`else
    // Fixed priority: pretending port 1 always won last makes port 0 win
    // every simultaneous request.
    assign last_winner = PORT_DMA;
`endif

    dram_arb_pick u_pick (
        .req0        (m0.req),
        .req1        (m1.req),
        .last_winner (last_winner),
        .winner      (grant_port),
        .valid       (grant_valid)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and all RAM/acknowledge outputs. The RAM lines are driven
    // only in ACCESS so they read as zero everywhere else, including
    // immediately on reset.
    always_comb begin
        state_next = state;
        ram_ce     = DISABLE;
        ram_we     = DISABLE;
        ram_addr   = '0;
        ram_sel    = '0;
        ram_wdata  = '0;
        ack0       = DISABLE;
        ack1       = DISABLE;
        busy       = DISABLE;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                ram_ce     = ENABLE;
                ram_we     = cmd_we;
                ram_addr   = cmd_addr;
                ram_sel    = cmd_sel;
                ram_wdata  = cmd_wdata;
                busy       = ENABLE;
                state_next = RESP;
            end
            RESP: begin
                ack0       = (cmd_port == PORT_CPU);
                ack1       = (cmd_port == PORT_DMA);
                busy       = ENABLE;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command registers: the winner's request is latched once in IDLE and
    // held for the rest of the transaction, so later changes on req or the
    // command inputs do not disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_we    <= 1'b0;
            cmd_port  <= PORT_CPU;
            cmd_addr  <= '0;
            cmd_sel   <= '0;
            cmd_wdata <= '0;
        end else if (grant_take) begin
            cmd_port <= grant_port;
            if (grant_port == PORT_DMA) begin
                cmd_we    <= m1.we;
                cmd_addr  <= m1.addr;
                cmd_sel   <= m1.sel;
                cmd_wdata <= m1.wdata;
            end else begin
                cmd_we    <= m0.we;
                cmd_addr  <= m0.addr;
                cmd_sel   <= m0.sel;
                cmd_wdata <= m0.wdata;
            end
        end
    end

    // Read data capture at the edge that ends ACCESS. Each port's register
    // changes only on its own reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if ((state == ACCESS) && !cmd_we) begin
            if (cmd_port == PORT_DMA) begin
                rdata1 <= ram_rdata;
            end else begin
                rdata0 <= ram_rdata;
            end
        end
    end

    assign m0.ack   = ack0;
    assign m1.ack   = ack1;
    assign m0.rdata = rdata0;
    assign m1.rdata = rdata1;

endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-port arbiter and sequencer in front of the byte-lane data RAM. The RAM has a synchronous write and a combinational read. This block shares it between the CPU memory stage (port 0) and the DMA/debug loader (port 1). It latches one request at a time, drives the RAM control, address, byte-select and write-data lines for exactly one cycle, captures read data, and returns a one-cycle acknowledge to the winning requester. It sits between the MEM-stage/DMA masters and the data RAM instance.

## Interface
Parameters:
- AW, 32, address width passed through to the RAM.
- DW, 32, data width; the byte-select width is DW/8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req  in  1  port 0 request; held high until m0_ack.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  AW  port 0 byte address.
- m0_sel  in  DW/8  port 0 byte lanes.
- m0_wdata  in  DW  port 0 write data.
- m0_ack  out  1  port 0 completion pulse.
- m0_rdata  out  DW  port 0 read data, registered.
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1.
- ram_ce  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_sel  out  DW/8  RAM byte lanes.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM combinational read data.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- State machine: IDLE, ACCESS, RESP.
- **IDLE**:
  - If any req is high, choose a winner, latch its we/addr/sel/wdata into the command registers and record the winner index. Next state is ACCESS.
  - Otherwise stay in IDLE.
- **ACCESS**:
  - ram_ce=1. ram_we, ram_addr, ram_sel and ram_wdata come from the command registers.
  - On a write, the RAM commits at the edge that ends ACCESS.
  - On a read, ram_rdata is captured into the winner's rdata register at that same edge.
  - Next state is RESP, unconditionally.
- **RESP**:
  - The winner's ack is high for this one cycle. Next state is IDLE, unconditionally.
  - No request is sampled in RESP. The requester drops or renews req at the edge that ends RESP.
- Outside ACCESS: ram_ce=0, ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0.
- m*_rdata is loaded only on a read by that port. It holds its value through writes and through the other port's transactions.
- Dropping req during ACCESS or RESP does not cancel the transaction: the write still commits and ack still pulses.
- A write with sel=0 still runs the full sequence and modifies no bytes.
- Request inputs are ignored except when sampled in IDLE.
- **Reset (asserted at any time, including mid-transaction)**:
  - state goes to IDLE, and all outputs and command registers go to 0.
  - The arbitration pointer is set so that port 0 wins first.
  - An in-flight ACCESS is abandoned and its write is not guaranteed.

## Timing
- A req first seen high at edge N (state IDLE) gives ACCESS in cycle N+1 and ack in cycle N+2. Read data is valid on m*_rdata from cycle N+2 onward.
- One transaction every 3 cycles at most. No back-to-back ACCESS cycles.
- ack is a single-cycle pulse. The two ack outputs are never high together.
- busy is 1 in ACCESS and RESP, and 0 in IDLE and after reset.

## Configuration
- DRAM_ARB_RR_EN defined:
  - Round-robin. When both ports request in IDLE, the port that did not win last wins.
  - The last-winner pointer updates on every grant and resets to "port 1 last".
- DRAM_ARB_RR_EN undefined:
  - Fixed priority: port 0 always wins a simultaneous request.
  - No pointer register exists.

## Structure
- Shared package dram_arb_pkg holds:
  - state encodings IDLE=2'd0, ACCESS=2'd1, RESP=2'd2;
  - port index constants PORT_CPU=1'b0 and PORT_DMA=1'b1;
  - the Enable/Disable constants used across the codebase.
- One combinational sub-module, dram_arb_pick, takes the two req bits and the last-winner pointer and returns the winner index and a valid flag. Its pointer input is tied off when DRAM_ARB_RR_EN is undefined.

## Test plan
- m0 writes 32'hDEADBEEF to addr 32'h10 with sel=4'hF, then reads it back. Required: ram_ce high in exactly one cycle per transaction, m0_ack 2 cycles after each req sample, and m0_rdata=32'hDEADBEEF.
- Byte write to addr 32'h10 with sel=4'b0100 and data 32'h00AA0000, then a read. Required: m0_rdata=32'hDEAABEEF.
- Both reqs rise in the same cycle for 4 transactions each. With RR_EN, grant order is 0,1,0,1,0,1,0,1. Without RR_EN, all four port-0 transactions complete before any port-1 transaction.
- m1 reads while m0_rdata holds 32'h12345678. Required: m0_rdata is unchanged and m1_rdata gets the RAM word.
- m0 drops req during ACCESS of a write. Required: the write commits and m0_ack still pulses once.
- rst asserted during ACCESS. Required: all outputs are immediately 0 and busy=0. After release, a simultaneous request is granted to port 0 first.
